// File: rtl/train_balancer_pkg.sv
// Shared types and helpers for the train balancer station-report aggregation slice.
package train_balancer_pkg;

    localparam int INT_DEFAULT = 31;

    // Wide enough for any table depth; narrower station-id ports are zero-extended into it.
    typedef logic [15:0] station_id_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_PUBLISH
    } agg_state_t;

    typedef logic [63:0] word_max_t;

    function automatic word_max_t clamp_percentage(input word_max_t s, input word_max_t p);
        return (s > p) ? p : s;
    endfunction

endpackage

// File: rtl/station_table.sv
// Per-station table of last value, presence and (with STATION_AGEING_EN) age.
// One shared address for the combinational read and the single write port.
module station_table #(
    parameter int N  = 16,
    parameter int DW = 32,
`ifdef STATION_AGEING_EN
    parameter int AW = 3,
`endif
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_idx,
    input  logic          i_we,
    input  logic [DW-1:0] i_value,
    input  logic          i_present,
`ifdef STATION_AGEING_EN
    input  logic [AW-1:0] i_age,
    output logic [AW-1:0] o_age,
`endif
    output logic [DW-1:0] o_value,
    output logic          o_present
);

    logic [N-1:0]  r_present;
    logic [DW-1:0] r_value [N];
`ifdef STATION_AGEING_EN
    logic [AW-1:0] r_age [N];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_present <= '0;
        end else if (i_we) begin
            r_present[i_idx] <= i_present;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_we) begin
            r_value[i_idx] <= i_value;
`ifdef STATION_AGEING_EN
            r_age[i_idx]   <= i_age;
`endif
        end
    end

    assign o_value   = r_value[i_idx];
    assign o_present = r_present[i_idx];
`ifdef STATION_AGEING_EN
    assign o_age     = r_age[i_idx];
`endif

endmodule

// File: rtl/station_report_aggregator.sv
// Aggregates per-station percentage reports into network-wide totals published once per epoch.
// Define STATION_AGEING_EN to age entries on each epoch sweep and evict silent stations.
module station_report_aggregator
    import train_balancer_pkg::*;
#(
    parameter int MAX_STATIONS = 16,
    parameter int INT          = INT_DEFAULT,
    parameter int EPOCH_TICKS  = 60,
    parameter int STALE_EPOCHS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [INT:0]                    precision,
    input  logic                            report_valid,
    output logic                            report_ready,
    input  logic [$clog2(MAX_STATIONS)-1:0] report_station_id,
    input  logic [INT:0]                    report_percentage,
    output logic [INT:0]                    total_percentage_stored,
    output logic [INT:0]                    number_of_stations,
    output logic                            totals_valid,
    output logic                            bad_id
);

    localparam int DW = INT + 1;
    localparam int IW = $clog2(MAX_STATIONS);
    localparam int EW = $clog2(EPOCH_TICKS);
`ifdef STATION_AGEING_EN
    localparam int AW = $clog2(STALE_EPOCHS + 1);
`endif

    if (EPOCH_TICKS < MAX_STATIONS + 2) begin : g_bad_epoch
        $error("EPOCH_TICKS must be at least MAX_STATIONS+2");
    end
    if (STALE_EPOCHS < 1) begin : g_bad_stale
        $error("STALE_EPOCHS must be at least 1");
    end

    agg_state_t    r_state, w_state_nxt;
    logic [EW-1:0] r_epoch;
    logic [DW-1:0] r_sum, r_count, r_total, r_nst;
    logic          r_totals_valid, r_bad_id;
    logic [DW-1:0] w_sum_nxt, w_count_nxt;
    logic          w_bad_nxt, w_tick, w_accept;
    station_id_t   w_id_ext;
    logic [DW-1:0] w_clamped;

    logic [IW-1:0] w_rd_idx;
    logic          w_we, w_wr_present, w_rd_present;
    logic [DW-1:0] w_wr_value, w_rd_value;
`ifdef STATION_AGEING_EN
    logic [IW-1:0] r_sweep_idx;
    logic [AW-1:0] w_wr_age, w_rd_age;
`endif

    assign w_tick    = (r_epoch == EW'(EPOCH_TICKS - 1));
    assign w_id_ext  = station_id_t'(report_station_id);
    assign w_clamped = DW'(clamp_percentage(word_max_t'(report_percentage), word_max_t'(precision)));

    assign report_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept     = report_valid && report_ready;

    station_table #(
        .N (MAX_STATIONS),
`ifdef STATION_AGEING_EN
        .AW(AW),
`endif
        .DW(DW)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .i_idx    (w_rd_idx),
        .i_we     (w_we),
        .i_value  (w_wr_value),
        .i_present(w_wr_present),
`ifdef STATION_AGEING_EN
        .i_age    (w_wr_age),
        .o_age    (w_rd_age),
`endif
        .o_value  (w_rd_value),
        .o_present(w_rd_present)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_sum_nxt    = r_sum;
        w_count_nxt  = r_count;
        w_bad_nxt    = r_bad_id;
        w_we         = 1'b0;
        w_wr_value   = w_clamped;
        w_wr_present = 1'b1;
        w_rd_idx     = report_station_id;
`ifdef STATION_AGEING_EN
        w_wr_age     = '0;
        if (r_state == ST_SWEEP) w_rd_idx = r_sweep_idx;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_id_ext >= station_id_t'(MAX_STATIONS)) begin
                        w_bad_nxt = 1'b1;
                    end else begin
                        w_we = 1'b1;
                        if (w_rd_present) begin
                            w_sum_nxt = r_sum - w_rd_value + w_clamped;
                        end else begin
                            w_sum_nxt   = r_sum + w_clamped;
                            w_count_nxt = r_count + DW'(1);
                        end
                    end
                end
                if (w_tick) begin
`ifdef STATION_AGEING_EN
                    w_state_nxt = ST_SWEEP;
`else
                    w_state_nxt = ST_PUBLISH;
`endif
                end
            end
`ifdef STATION_AGEING_EN
            ST_SWEEP: begin
                w_wr_value = w_rd_value;
                if (w_rd_present) begin
                    w_we     = 1'b1;
                    w_wr_age = w_rd_age + AW'(1);
                    if (w_wr_age == AW'(STALE_EPOCHS)) begin
                        w_wr_present = 1'b0;
                        w_sum_nxt    = r_sum - w_rd_value;
                        w_count_nxt  = r_count - DW'(1);
                    end
                end
                if (r_sweep_idx == IW'(MAX_STATIONS - 1)) w_state_nxt = ST_PUBLISH;
            end
`endif
            ST_PUBLISH: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_epoch        <= '0;
            r_sum          <= '0;
            r_count        <= '0;
            r_total        <= '0;
            r_nst          <= DW'(1);
            r_totals_valid <= 1'b0;
            r_bad_id       <= 1'b0;
`ifdef STATION_AGEING_EN
            r_sweep_idx    <= '0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_epoch        <= w_tick ? '0 : r_epoch + EW'(1);
            r_sum          <= w_sum_nxt;
            r_count        <= w_count_nxt;
            r_bad_id       <= w_bad_nxt;
            r_totals_valid <= (r_state == ST_PUBLISH);
            if (r_state == ST_PUBLISH) begin
                r_total <= r_sum;
                r_nst   <= (r_count == '0) ? DW'(1) : r_count;
            end
`ifdef STATION_AGEING_EN
            r_sweep_idx <= (r_state == ST_SWEEP) ? r_sweep_idx + IW'(1) : '0;
`endif
        end
    end

    assign total_percentage_stored = r_total;
    assign number_of_stations      = r_nst;
    assign totals_valid            = r_totals_valid;
    assign bad_id                  = r_bad_id;

endmodule

// File: doc/station_report_aggregator.md
# station_report_aggregator

Collects the per-station `percentage_stored` reports emitted by every dropoff station and produces the network-wide `total_percentage_stored` (R) and `number_of_stations` (G) consumed by each dropoff station's trains-limit logic. It keeps a per-station table of the last reported value and running sums, and evicts stations that stop reporting. Totals are published once per epoch as a registered, stable snapshot.

## Interface
- `MAX_STATIONS`, 16: table depth; station ids are `0..MAX_STATIONS-1`.
- `INT`, 31: MSB index of all data words.
- `EPOCH_TICKS`, 60: clock cycles per publish epoch; must be `>= MAX_STATIONS+2`, checked by an elaboration assertion.
- `STALE_EPOCHS`, 4: number of silent epochs after which a station is evicted; must be `>= 1`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  **synchronous, active-high reset**.
- `precision`  in  `INT+1`  full-scale value (P); reports are clamped to it.
- `report_valid`  in  1  station report offered.
- `report_ready`  out  1  aggregator accepts a report this cycle.
- `report_station_id`  in  `$clog2(MAX_STATIONS)`  reporting station id.
- `report_percentage`  in  `INT+1`  reported S.
- `total_percentage_stored`  out  `INT+1`  published R.
- `number_of_stations`  out  `INT+1`  published G; never 0.
- `totals_valid`  out  1  one-cycle pulse when new totals are first visible.
- `bad_id`  out  1  sticky; set when an out-of-range id is accepted.

## Operation
- Per-entry table state: `value`, `present`, and `age` (saturating at `STALE_EPOCHS`). Running registers: `sum` and `count`.
- Handshake: a report transfers when `report_valid && report_ready`. A report with `report_valid` high but `report_ready` low must be held stable by the sender.
- Clamp: `v = min(report_percentage, precision)`.
- Accepted report for a present entry: `sum <= sum - value + v`. Then set `value <= v` and `age <= 0`.
- Accepted report for an absent entry: `sum <= sum + v` and `count <= count + 1`. Then set `present <= 1`, `value <= v` and `age <= 0`.
- An id `>= MAX_STATIONS` (only possible when `MAX_STATIONS` is not a power of 2) is accepted and discarded, and sets `bad_id`.
- Width: `precision * MAX_STATIONS` must fit in `INT+1` bits. This is the integrator's obligation; there is no saturation logic.
- FSM states:
  - IDLE: `report_ready = 1`. On the epoch tick (epoch counter reaches `EPOCH_TICKS-1`), go to SWEEP. A report accepted in that same cycle is applied before the sweep.
  - SWEEP: `report_ready = 0`. Visits index 0 through `MAX_STATIONS-1`, one entry per cycle. For each present entry, `age` is incremented. If the new age equals `STALE_EPOCHS`, the entry is evicted: `present <= 0`, `sum -= value`, `count -= 1`. After the last index, go to PUBLISH.
  - PUBLISH: `report_ready = 0`, lasts one cycle, then IDLE. Loads the output registers:
    - `total_percentage_stored <= sum`.
    - `number_of_stations <= (count == 0) ? 1 : count`.
- The epoch counter free-runs in all states and wraps from `EPOCH_TICKS-1` to 0.

## Timing
- Reset values:
  - `total_percentage_stored = 0`, `number_of_stations = 1`.
  - `totals_valid = 0`, `bad_id = 0`.
  - `report_ready = 0` while `rst` is high; state is IDLE and the epoch counter is 0.
  - All table entries absent; `sum = 0`, `count = 0`.
- `report_ready` is high in the first cycle after `rst` deasserts.
- Publish timing:
  - Epoch tick in cycle t → SWEEP occupies t+1 … t+MAX_STATIONS → PUBLISH at t+MAX_STATIONS+1.
  - New outputs and the `totals_valid` pulse are first visible at t+MAX_STATIONS+2.
- Outputs hold between publishes. Accepted reports never change the outputs before the next PUBLISH.
- `rst` asserted mid-SWEEP or in PUBLISH aborts the operation. The next cycle shows reset values.

## Configuration
- `STATION_AGEING_EN` defined: ageing and eviction behave as described above.
- `STATION_AGEING_EN` not defined:
  - `age` storage and the sweep datapath are omitted; entries are never evicted.
  - The epoch tick goes IDLE → PUBLISH directly; outputs are visible 2 cycles after the tick.
  - `report_ready` is low for the PUBLISH cycle only.

## Structure
- Package `train_balancer_pkg` holds:
  - the `station_id_t` typedef;
  - the aggregator state enum;
  - the shared `INT` default;
  - a `clamp_percentage` function.
- One natural sub-module, `station_table`: the value, present and age arrays, with a single update port shared by report writes and sweep writes. The FSM guarantees at most one writer per cycle.

## Test plan
All scenarios use MAX_STATIONS=4, EPOCH_TICKS=16, STALE_EPOCHS=2, precision=1000.
- Reset → outputs are 0/1/0/0; `report_ready` goes high the cycle after `rst` falls.
- Reports id0=400 and id1=600 → after the next pulse, R=1000, G=2.
- id0 re-reports 100 → next pulse shows R=700, G=2 (replace, not add).
- id2 reports 1500 → clamped; next pulse shows R=1700, G=3.
- id1 silent for 2 epochs, others refreshed:
  - with `STATION_AGEING_EN`: id1 is evicted on the 2nd sweep; R=1100, G=2;
  - without the macro: R=1700, G=3.
- A report accepted on the epoch-tick cycle is included in that epoch's publish. `rst` pulsed at sweep index 2 → reset values; no `totals_valid` pulse occurs for that epoch.
